// File: rtl/sv_meta5_credit_buf_if.sv
// rtl/sv_meta5_credit_buf_if.sv - result metadata type and credit-buffer bus interface
package sv_meta5_pkg;
    typedef struct packed {
        logic [7:0]  tag;
        logic [23:0] data;
    } sv_meta5_t;
endpackage

interface sv_meta5_credit_buf_if #(
    parameter int DEPTH   = 64,
    parameter int DEPTH_L = $clog2(DEPTH)
);
    logic                   acc;
    logic                   w;
    logic                   i_v;
    sv_meta5_pkg::sv_meta5_t i_m;
    logic                   o_r;
    logic                   o_v;
    sv_meta5_pkg::sv_meta5_t o_m;
    logic [DEPTH_L:0]       o_cnt;
    logic                   o_err;

    modport master (
        output acc, i_v, i_m, o_r,
        input  w, o_v, o_m, o_cnt, o_err
    );

    modport slave (
        input  acc, i_v, i_m, o_r,
        output w, o_v, o_m, o_cnt, o_err
    );
endinterface

// File: rtl/sv_meta5_credit_buf.sv
// rtl/sv_meta5_credit_buf.sv - show-ahead result FIFO with upstream credit/wait generation
module sv_meta5_credit_buf #(
    parameter int DEPTH   = 64,
    parameter int MARGIN  = 4,
    parameter int DEPTH_L = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    sv_meta5_credit_buf_if.slave  bus
);
    localparam logic [DEPTH_L:0] FULL_CNT = (DEPTH_L + 1)'(DEPTH);

    sv_meta5_pkg::sv_meta5_t mem_q [DEPTH];

    logic [DEPTH_L-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_L-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_L:0]   cnt_q, cnt_d;
    logic [DEPTH_L:0]   r_q, r_d;
    logic               w_q, w_d;
    logic               err_q, err_d;

    logic full;
    logic pop;
    logic push;
    logic drop;
    logic r_over;
    logic r_under;

    assign full = (cnt_q == FULL_CNT);
    assign pop  = (cnt_q != '0) && bus.o_r;
    // A full FIFO can still take a result when the head leaves in the same cycle.
    assign push = bus.i_v && (!full || pop);
    assign drop = bus.i_v && full && !pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + DEPTH_L'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + DEPTH_L'(1);
        end
        if (push && !pop) begin
            cnt_d = cnt_q + (DEPTH_L + 1)'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - (DEPTH_L + 1)'(1);
        end
    end

    // Credits count jobs in flight plus results still buffered; saturate on misuse.
    always_comb begin
        r_d     = r_q;
        r_over  = 1'b0;
        r_under = 1'b0;
        if (bus.acc && !pop) begin
            if (r_q == FULL_CNT) begin
                r_over = 1'b1;
            end else begin
                r_d = r_q + (DEPTH_L + 1)'(1);
            end
        end else if (pop && !bus.acc) begin
            if (r_q == '0) begin
                r_under = 1'b1;
            end else begin
                r_d = r_q - (DEPTH_L + 1)'(1);
            end
        end
    end

    always_comb begin
        w_d   = (int'(r_d) + MARGIN) >= DEPTH;
        err_d = err_q || drop || r_over || r_under;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            r_q      <= '0;
            w_q      <= 1'b1;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            r_q      <= r_d;
            w_q      <= w_d;
            err_q    <= err_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wr_ptr_q] <= bus.i_m;
        end
    end

    assign bus.o_v   = (cnt_q != '0);
    assign bus.o_m   = mem_q[rd_ptr_q];
    assign bus.o_cnt = cnt_q;
    assign bus.w     = w_q;
    assign bus.o_err = err_q;
endmodule

// File: tb/tb_sv_meta5_credit_buf.sv
// tb/tb_sv_meta5_credit_buf.sv - randomized self-checking bench with queue reference model
module tb_sv_meta5_credit_buf;
    localparam int DEPTH  = 8;
    localparam int MARGIN = 2;

    typedef sv_meta5_pkg::sv_meta5_t meta_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sv_meta5_credit_buf_if #(.DEPTH(DEPTH)) bus ();

    sv_meta5_credit_buf #(.DEPTH(DEPTH), .MARGIN(MARGIN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    meta_t    m_q[$];
    int       m_r;
    bit       m_err;
    bit       m_w;
    logic [7:0] got_tags[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        check_eq("o_v", 64'(bus.o_v), 64'(m_q.size() != 0));
        check_eq("o_cnt", 64'(bus.o_cnt), 64'(m_q.size()));
        check_eq("o_err", 64'(bus.o_err), 64'(m_err));
        check_eq("w", 64'(bus.w), 64'(m_w));
        if (m_q.size() != 0) begin
            check_eq("o_m", 64'(bus.o_m), 64'(m_q[0]));
        end
    endtask

    // Called at a falling edge: check state, drive inputs, advance model and clock.
    task automatic cycle(input bit a, input bit v, input meta_t m, input bit r);
        bit pop;
        bit full;
        check_outputs();
        bus.acc = a;
        bus.i_v = v;
        bus.i_m = m;
        bus.o_r = r;
        pop  = (m_q.size() != 0) && r;
        full = (m_q.size() == DEPTH);
        if (pop) begin
            got_tags.push_back(bus.o_m.tag);
            void'(m_q.pop_front());
        end
        if (v) begin
            if (!full || pop) m_q.push_back(m);
            else m_err = 1'b1;
        end
        if (a && !pop) begin
            if (m_r == DEPTH) m_err = 1'b1;
            else m_r++;
        end else if (pop && !a) begin
            if (m_r == 0) m_err = 1'b1;
            else m_r--;
        end
        m_w = (m_r + MARGIN) >= DEPTH;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        bus.acc = 1'b0;
        bus.i_v = 1'b0;
        bus.o_r = 1'b0;
        bus.i_m = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_q.delete();
        got_tags.delete();
        m_r   = 0;
        m_err = 1'b0;
        m_w   = 1'b1;
    endtask

    function automatic meta_t mk(input logic [7:0] tag);
        meta_t m;
        m.tag  = tag;
        m.data = 24'($urandom);
        return m;
    endfunction

    initial begin
        meta_t a5;
        bus.acc = 1'b0;
        bus.i_v = 1'b0;
        bus.o_r = 1'b0;
        bus.i_m = '0;
        @(negedge clk);

        // Reset behaviour
        do_reset();
        check_eq("rst_ov", 64'(bus.o_v), 64'd0);
        check_eq("rst_cnt", 64'(bus.o_cnt), 64'd0);
        check_eq("rst_err", 64'(bus.o_err), 64'd0);
        check_eq("rst_w1", 64'(bus.w), 64'd1);
        cycle(0, 0, '0, 0);
        check_eq("rst_w2", 64'(bus.w), 64'd0);

        // Single job
        do_reset();
        a5 = 32'hA5A5A5A5;
        cycle(1, 0, '0, 1);
        repeat (9) cycle(0, 0, '0, 1);
        cycle(0, 1, a5, 1);
        check_eq("single_ov", 64'(bus.o_v), 64'd1);
        check_eq("single_om", 64'(bus.o_m), 64'hA5A5A5A5);
        cycle(0, 0, '0, 1);
        check_eq("single_cnt", 64'(bus.o_cnt), 64'd0);
        check_eq("single_err", 64'(bus.o_err), 64'd0);

        // Throttle
        do_reset();
        repeat (6) cycle(1, 0, '0, 0);
        check_eq("thr_w_on", 64'(bus.w), 64'd1);
        cycle(0, 1, mk(8'h11), 0);
        check_eq("thr_w_hold", 64'(bus.w), 64'd1);
        cycle(0, 0, '0, 1);
        check_eq("thr_w_off", 64'(bus.w), 64'd0);

        // Ordering with toggling ready
        do_reset();
        for (int i = 0; i < 8; i++) cycle(0, 1, mk(8'(i)), (i % 2) == 0);
        repeat (10) cycle(0, 0, '0, 1);
        check_eq("ord_n", 64'(got_tags.size()), 64'd8);
        for (int i = 0; i < 8 && i < got_tags.size(); i++) check_eq("ord_tag", 64'(got_tags[i]), 64'(i));

        // Overflow
        do_reset();
        for (int i = 0; i < 9; i++) cycle(0, 1, mk(8'(i)), 0);
        check_eq("ovf_cnt", 64'(bus.o_cnt), 64'd8);
        check_eq("ovf_err", 64'(bus.o_err), 64'd1);
        repeat (10) cycle(0, 0, '0, 1);
        check_eq("ovf_err_hold", 64'(bus.o_err), 64'd1);
        check_eq("ovf_n", 64'(got_tags.size()), 64'd8);
        for (int i = 0; i < 8 && i < got_tags.size(); i++) check_eq("ovf_tag", 64'(got_tags[i]), 64'(i));

        // Full plus simultaneous pop
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1, 1, mk(8'(i)), 0);
        cycle(0, 1, mk(8'h88), 1);
        check_eq("fullpop_cnt", 64'(bus.o_cnt), 64'd8);
        check_eq("fullpop_err", 64'(bus.o_err), 64'd0);

        // Random traffic with varying pressure and occasional mid-run reset
        do_reset();
        for (int ph = 0; ph < 4; ph++) begin
            int pr;
            pr = (ph == 0) ? 20 : (ph == 1) ? 50 : (ph == 2) ? 80 : 95;
            for (int n = 0; n < 600; n++) begin
                bit a;
                bit v;
                bit r;
                a = ($urandom_range(99) < 35) && !(m_w && ph < 3);
                v = $urandom_range(99) < 40;
                r = $urandom_range(99) < pr;
                if ($urandom_range(399) == 0) begin
                    do_reset();
                    check_eq("rnd_rst_ov", 64'(bus.o_v), 64'd0);
                end
                cycle(a, v, mk(8'($urandom)), r);
            end
        end
        check_outputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sv_meta5_credit_buf.md
SV_META5_CREDIT_BUF -- requirements
Module: sv_meta5_credit_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 64, result FIFO entries (power of 2, >= 4).
REQ-002 SHALL have parameter MARGIN, default 4, credits held back to absorb upstream accepts that occur after wait asserts.
REQ-003 SHALL have parameter DEPTH_L, default $clog2(DEPTH), FIFO index width.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port acc  input  1  one-cycle pulse per job accepted by the sigverify stage (its i_v & i_r).
REQ-007 SHALL have port w  output  1  wait to the upstream sigverify stage; 1 means issue no new job.
REQ-008 SHALL have port i_v  input  1  result valid from the sigverify stage; no backpressure.
REQ-009 SHALL have port i_m  input  $bits(sv_meta5_t)  result metadata.
REQ-010 SHALL have port o_r  input  1  downstream ready.
REQ-011 SHALL have port o_v  output  1  downstream valid.
REQ-012 SHALL have port o_m  output  $bits(sv_meta5_t)  head-of-FIFO result.
REQ-013 SHALL have port o_cnt  output  DEPTH_L+1  FIFO occupancy.
REQ-014 SHALL have port o_err  output  1  sticky error flag.

Function
REQ-015 SHALL store results in a show-ahead FIFO of DEPTH entries; push = i_v & (not full, or o_v & o_r in the same cycle).
REQ-016 SHALL pop when o_v & o_r; o_v = (o_cnt != 0); o_m = head entry, valid while o_v = 1.
REQ-017 SHALL make a result pushed at edge t visible at o_v/o_m in cycle t+1 (one-cycle latency), and SHALL emit results in arrival order.
REQ-018 SHALL update o_cnt by +1 on push only, -1 on pop only, and leave it unchanged on simultaneous push and pop.
REQ-019 SHALL keep a credit counter R (DEPTH_L+1 bits) = jobs accepted upstream but not yet popped: +1 on acc, -1 on pop, unchanged when both occur in the same cycle.
REQ-020 SHALL register w <= ((R_next + MARGIN) >= DEPTH), where R_next is the value R takes at the same edge.
REQ-021 SHALL saturate R at DEPTH when acc arrives at R == DEPTH, and set o_err.
REQ-022 SHALL hold R at 0 when a pop occurs at R == 0, and set o_err.
REQ-023 SHALL drop i_v arriving while the FIFO is full with no same-cycle pop, leave the FIFO contents and o_cnt unchanged, and set o_err.
REQ-024 SHALL keep o_err set until rst.
REQ-025 SHALL treat acc and i_v as independent; any combination of acc, i_v and pop in one cycle is legal.

Reset
REQ-026 SHALL, while rst = 1, set FIFO pointers, o_cnt and R to 0, o_v to 0, o_err to 0 and w to 1.
REQ-027 SHALL hold w = 1 in the first cycle after rst deasserts, then follow REQ-020; w therefore reads 0 from the second cycle.
REQ-028 SHALL let rst asserted mid-operation discard all stored results and credits at that edge, with no o_v pulse afterwards.
REQ-029 SHALL not require FIFO RAM contents to be reset.

Verification
REQ-030 Reset: with DEPTH=8, MARGIN=2, pulse rst for 2 cycles -> o_v=0, o_cnt=0, o_err=0; w=1 in the first cycle after reset, w=0 in the second.
REQ-031 Single job: acc at cycle 0, i_v with i_m=0xA5.. at cycle 10, o_r=1 -> o_v=1 and o_m=0xA5.. at cycle 11, popped there; R=0 and o_cnt=0 at cycle 12.
REQ-032 Throttle: o_r=0, six acc pulses -> w=1 the cycle after the 6th acc (6+2 >= 8); one push then one pop -> R=5, and w=0 the cycle after the pop.
REQ-033 Ordering: 8 back-to-back i_v with tags 0..7 while o_r toggles 1,0,1,0 -> outputs are tags 0..7 in order, none lost or duplicated.
REQ-034 Overflow: 9 consecutive i_v, o_r=0 -> 9th dropped, o_cnt=8, o_err=1 and held until rst; draining then yields tags 0..7.
REQ-035 Full plus simultaneous pop: at o_cnt=8, i_v with o_r=1 -> push accepted, o_cnt stays 8, o_err stays 0.
